// File: rtl/spi_slave_resp_if.sv
// rtl/spi_slave_resp_if.sv - SPI pad and memory-port bundle for the SPI slave responder
interface spi_slave_resp_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 7
);
    logic                 sclk;
    logic                 cs_n;
    logic                 mosi;
    logic                 miso;
    logic                 miso_oe;
    logic                 mem_wen;
    logic [ADDRWIDTH-1:0] mem_waddr;
    logic [DATAWIDTH-1:0] mem_wdata;
    logic                 mem_ren;
    logic [ADDRWIDTH-1:0] mem_raddr;
    logic [DATAWIDTH-1:0] mem_rdata;
    logic                 busy;
    logic                 frame_done;
    logic                 err_abort;

    modport slave (
        input  sclk, cs_n, mosi, mem_rdata,
        output miso, miso_oe, mem_wen, mem_waddr, mem_wdata,
               mem_ren, mem_raddr, busy, frame_done, err_abort
    );

    modport master (
        output sclk, cs_n, mosi, mem_rdata,
        input  miso, miso_oe, mem_wen, mem_waddr, mem_wdata,
               mem_ren, mem_raddr, busy, frame_done, err_abort
    );
endinterface

// File: rtl/spi_slave_resp.sv
// rtl/spi_slave_resp.sv - oversampled SPI mode-0 slave doing burst reads/writes on a sync memory port
module spi_slave_resp #(
    parameter int DATAWIDTH   = 8,
    parameter int ADDRWIDTH   = 7,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    spi_slave_resp_if.slave bus
);
    localparam int BW = $clog2(DATAWIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATAWIDTH-2:0]   rx_q, rx_d;
    logic [DATAWIDTH-1:0]   tx_q, tx_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic                   armed_q, armed_d;
    logic                   busy_q, busy_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   mem_wen_q, mem_wen_d;
    logic [ADDRWIDTH-1:0]   mem_waddr_q, mem_waddr_d;
    logic [DATAWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   mem_ren_q, mem_ren_d;
    logic [ADDRWIDTH-1:0]   mem_raddr_q, mem_raddr_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_abort_q, err_abort_d;

    logic                 sclk_cur, sclk_prev, cs_cur, cs_prev, mosi_s;
    logic                 sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                 word_end;
    logic [DATAWIDTH-1:0] word_in;

    // Edges come from the two oldest synchronizer stages; the oldest mosi stage
    // lines up with the sclk sample taken while it was still low.
    assign sclk_cur  = sclk_sync_q[SYNC_STAGES-2];
    assign sclk_prev = sclk_sync_q[SYNC_STAGES-1];
    assign cs_cur    = cs_sync_q[SYNC_STAGES-2];
    assign cs_prev   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_cur & ~sclk_prev;
    assign sclk_fall = ~sclk_cur & sclk_prev;
    assign cs_fall   = ~cs_cur & cs_prev;
    assign cs_rise   = cs_cur & ~cs_prev;
    assign word_end  = sclk_rise && (bitcnt_q == LAST_BIT);
    assign word_in   = {rx_q, mosi_s};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sclk_sync_q  <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            bitcnt_q     <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            addr_q       <= '0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            mem_ren_q    <= 1'b0;
            mem_raddr_q  <= '0;
            frame_done_q <= 1'b0;
            err_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            bitcnt_q     <= bitcnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            rd_valid_q   <= rd_valid_d;
            mem_wen_q    <= mem_wen_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_ren_q    <= mem_ren_d;
            mem_raddr_q  <= mem_raddr_d;
            frame_done_q <= frame_done_d;
            err_abort_q  <= err_abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        // Sync flops reset low, so a cs_n still low across reset never arms us.
        armed_d      = armed_q | cs_cur;
        busy_d       = busy_q;
        rd_valid_d   = mem_ren_q;
        mem_wen_d    = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_ren_d    = 1'b0;
        mem_raddr_d  = mem_raddr_q;
        frame_done_d = 1'b0;
        err_abort_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (cs_fall && armed_q) begin
                state_d  = ST_CMD;
                bitcnt_d = '0;
                busy_d   = 1'b1;
            end
        end else if (cs_rise) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            busy_d   = 1'b0;
            if (state_q != ST_CMD && bitcnt_q == '0) begin
                frame_done_d = 1'b1;
            end else begin
                err_abort_d = 1'b1;
            end
        end else begin
            if (sclk_rise) begin
                rx_d     = word_in[DATAWIDTH-2:0];
                bitcnt_d = word_end ? '0 : bitcnt_q + 1'b1;
            end
            if (word_end) begin
                case (state_q)
                    ST_CMD: begin
                        addr_d = word_in[ADDRWIDTH-1:0];
                        if (word_in[DATAWIDTH-1]) begin
                            state_d     = ST_RDATA;
                            mem_ren_d   = 1'b1;
                            mem_raddr_d = word_in[ADDRWIDTH-1:0];
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        mem_wen_d   = 1'b1;
                        mem_waddr_d = addr_q;
                        mem_wdata_d = word_in;
                        addr_d      = addr_q + 1'b1;
                    end
                    default: begin
                        addr_d      = addr_q + 1'b1;
                        mem_ren_d   = 1'b1;
                        mem_raddr_d = addr_q + 1'b1;
                    end
                endcase
            end
            // The fall right after a word boundary belongs to the reload, not the shift.
            if (state_q == ST_RDATA && sclk_fall && bitcnt_q != '0) begin
                tx_d = {tx_q[DATAWIDTH-2:0], 1'b0};
            end
        end

        if (rd_valid_q) begin
            tx_d = bus.mem_rdata;
        end
    end

    assign bus.miso       = (state_q == ST_RDATA) ? tx_q[DATAWIDTH-1] : 1'b0;
    assign bus.miso_oe    = armed_q & ~cs_cur;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_waddr  = mem_waddr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_ren    = mem_ren_q;
    assign bus.mem_raddr  = mem_raddr_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err_abort  = err_abort_q;
endmodule

// File: tb/tb_spi_slave_resp.sv
// tb/tb_spi_slave_resp.sv - scoreboard bench for spi_slave_resp with a frame-level memory model
module tb_spi_slave_resp;
    localparam int DW = 8;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_resp_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus();

    spi_slave_resp #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .SYNC_STAGES(2)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [7:0]  tbmem     [0:127] = '{default: 8'h00};
    logic [7:0]  model_mem [0:127] = '{default: 8'h00};
    logic [14:0] exp_wr_q  [$];
    logic [6:0]  exp_ren_q [$];
    int          exp_evt_q [$];
    logic [7:0]  fb [0:15];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          half     = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h while nothing was expected", name, act);
    endtask

    always @(posedge clk) begin
        if (bus.mem_ren === 1'b1) bus.mem_rdata <= tbmem[bus.mem_raddr];
        if (bus.mem_wen === 1'b1) tbmem[bus.mem_waddr] <= bus.mem_wdata;
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.mem_wen === 1'b1) begin
                if (exp_wr_q.size() > 0)
                    check("mem_wen", 32'({bus.mem_waddr, bus.mem_wdata}), 32'(exp_wr_q.pop_front()));
                else unexpected("mem_wen", 32'({bus.mem_waddr, bus.mem_wdata}));
            end
            if (bus.mem_ren === 1'b1) begin
                if (exp_ren_q.size() > 0) check("mem_ren", 32'(bus.mem_raddr), 32'(exp_ren_q.pop_front()));
                else unexpected("mem_ren", 32'(bus.mem_raddr));
            end
            if (bus.frame_done === 1'b1 || bus.err_abort === 1'b1) begin
                if (exp_evt_q.size() > 0)
                    check("frame_end", 32'({bus.err_abort, bus.frame_done}),
                          (exp_evt_q.pop_front() == 1) ? 32'h2 : 32'h1);
                else unexpected("frame_end", 32'({bus.err_abort, bus.frame_done}));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic m);
        bus.mosi = b;
        wait_clk(half);
        m = bus.miso;
        bus.sclk = 1'b1;
        wait_clk(half);
        bus.sclk = 1'b0;
    endtask

    // Frame model: byte 0 is the command, every complete later byte is one data word
    // at cmd address + index (mod 128); reads fetch one address past the last full word.
    task automatic frame(input int nfull, input int part_bits, input int gap);
        logic       rd;
        logic [6:0] a;
        logic [7:0] exp_rd [0:15];
        logic [7:0] got;
        logic       m;
        rd = 1'b0;
        a  = 7'd0;
        if (nfull >= 1) begin
            rd = fb[0][7];
            a  = fb[0][6:0];
            for (int i = 0; i < nfull; i++) begin
                if (rd) begin
                    exp_ren_q.push_back(7'(a + i));
                    exp_rd[i] = model_mem[7'(a + i)];
                end else if (i >= 1) begin
                    exp_wr_q.push_back({7'(a + i - 1), fb[i]});
                    model_mem[7'(a + i - 1)] = fb[i];
                end
            end
        end
        exp_evt_q.push_back((nfull >= 1 && part_bits == 0) ? 0 : 1);

        bus.cs_n = 1'b0;
        wait_clk(2 * half);
        check("busy_in_frame", 32'({bus.busy, bus.miso_oe}), 32'h3);
        for (int i = 0; i < nfull; i++) begin
            got = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                xfer_bit(fb[i][b], m);
                got = {got[6:0], m};
            end
            if (rd && i >= 1) check("miso_byte", 32'(got), 32'(exp_rd[i-1]));
        end
        for (int b = 0; b < part_bits; b++) xfer_bit(fb[nfull][7-b], m);
        wait_clk(half);
        bus.cs_n = 1'b1;
        if (gap >= 6) begin
            wait_clk(5);
            check("busy_after_frame", 32'(bus.busy), 32'h0);
            wait_clk(gap - 5);
        end else begin
            wait_clk(gap);
        end
    endtask

    initial begin
        logic m;
        bus.sclk      = 1'b0;
        bus.cs_n      = 1'b1;
        bus.mosi      = 1'b0;
        rst           = 1'b1;
        wait_clk(3);
        check("reset_outputs",
              32'({bus.busy, bus.miso_oe, bus.miso, bus.mem_wen, bus.mem_ren,
                   bus.frame_done, bus.err_abort}), 32'h0);
        check("reset_buses", 32'({bus.mem_waddr, bus.mem_wdata, bus.mem_raddr}), 32'h0);
        rst = 1'b0;
        wait_clk(6);

        fb[0] = 8'h05; fb[1] = 8'hA1; fb[2] = 8'hB2;
        frame(3, 0, 10);
        fb[0] = 8'h10; fb[1] = 8'h3C; fb[2] = 8'hC3;
        frame(3, 0, 10);
        fb[0] = 8'h90; fb[1] = 8'hFF; fb[2] = 8'h00;
        frame(3, 0, 10);
        fb[0] = 8'h7F; fb[1] = 8'h11; fb[2] = 8'h22;
        frame(3, 0, 10);
        fb[0] = 8'h02; fb[1] = 8'hE5;
        frame(1, 5, 10);
        fb[0] = 8'h03; fb[1] = 8'h44;
        frame(2, 0, 10);
        fb[0] = 8'h83;
        frame(0, 4, 10);

        bus.cs_n = 1'b0;
        wait_clk(2 * half);
        for (int b = 0; b < 3; b++) xfer_bit(1'b0, m);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        for (int b = 0; b < 10; b++) xfer_bit(1'($urandom_range(0, 1)), m);
        check("ignored_after_reset", 32'({bus.busy, bus.miso_oe}), 32'h0);
        bus.cs_n = 1'b1;
        wait_clk(8);
        fb[0] = 8'h01; fb[1] = 8'h55;
        frame(2, 0, 10);

        fb[0] = 8'h00; fb[1] = 8'h80;
        frame(2, 0, 10);
        fb[0] = 8'h80; fb[1] = 8'h00;
        frame(2, 0, 10);

        fb[0] = 8'h20; fb[1] = 8'h9A;
        frame(2, 0, 1);
        fb[0] = 8'hA0; fb[1] = 8'h00;
        frame(2, 0, 10);

        for (int f = 0; f < 24; f++) begin
            half  = $urandom_range(4, 6);
            fb[0] = 8'($urandom_range(0, 255));
            for (int i = 1; i < 16; i++) fb[i] = 8'($urandom_range(0, 255));
            frame($urandom_range(1, 4),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                  ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(6, 12));
        end

        wait_clk(12);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
        check("ren_queue_drained", 32'(exp_ren_q.size()), 32'h0);
        check("evt_queue_drained", 32'(exp_evt_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_resp.md
Name: spi_slave_resp

Overview:
- SPI mode-0 slave responder: the far end of the SPI master path, answering single-master register/memory transactions.
- Oversamples SCLK/CS_N/MOSI on the system clock and decodes a command byte (R/W + address).
- Performs burst writes or reads against a synchronous memory port, with auto-incrementing addresses.
- Sits between the pads and a local BRAM/register file. One clock, no SCLK-domain logic.

Parameters:
- DATAWIDTH, 8: bits per SPI word and memory data width.
- ADDRWIDTH, 7: memory address width; must equal DATAWIDTH-1.
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and mosi (≥2).

Ports:
- clk  in  1  system clock; must be ≥8x the SCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from master; idle low (CPOL=0).
- cs_n  in  1  chip select from master, active low.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- miso_oe  out  1  MISO pad output enable.
- mem_wen  out  1  one-cycle write strobe.
- mem_waddr  out  ADDRWIDTH  write address.
- mem_wdata  out  DATAWIDTH  write data.
- mem_ren  out  1  one-cycle read strobe.
- mem_raddr  out  ADDRWIDTH  read address.
- mem_rdata  in  DATAWIDTH  read data, valid exactly 1 clk after mem_ren.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse: frame ended cleanly on a word boundary.
- err_abort  out  1  one-cycle pulse: frame ended mid-word.

Behaviour:
- Reset values: all outputs 0; state IDLE; armed=0.
- Asynchronous reset can assert mid-frame. After release, the block ignores the bus until a cs_n high period is seen (sets armed), so a partial frame is never decoded.
- Synchronizers: sclk, cs_n and mosi each pass SYNC_STAGES flops. Edges are detected from the last two stages: sclk_rise, sclk_fall, cs_fall, cs_rise.
- Mode 0 timing:
  - mosi is sampled on sclk_rise, MSB first.
  - miso shifts on sclk_fall.
  - Bit counter bitcnt is 0..DATAWIDTH-1 and wraps at the word boundary.
- States:
  - IDLE: on cs_fall with armed=1, go to CMD; bitcnt=0; busy=1.
  - CMD: shift in the command word. At the DATAWIDTH-th sclk_rise, bit[MSB]=1 means read, 0 means write; bits[ADDRWIDTH-1:0] load addr.
    - Write: go to WDATA.
    - Read: assert mem_ren with mem_raddr=addr the next clk, then go to RDATA.
  - WDATA: each completed word gives, on the clk after the last sclk_rise, mem_wen=1, mem_waddr=addr, mem_wdata=word. Then addr increments.
  - RDATA:
    - 1 clk after mem_ren, mem_rdata loads the tx shift register. miso drives its MSB immediately, before the next sclk_rise; the 8x oversampling guarantees this.
    - On each completed word (DATAWIDTH-th sclk_rise), addr increments, mem_ren issues for the new addr, and tx reloads 1 clk later. The final sclk_fall of a word must not shift in a stale bit; the reload wins over the shift.
    - Received mosi bits are discarded.
- Address increment: modulo 2^ADDRWIDTH (0x7F -> 0x00).
- miso_oe = 1 whenever the synchronized cs_n is low and armed. miso = 0 in CMD/WDATA, tx MSB in RDATA, 0 in IDLE.
- cs_rise in any non-IDLE state: go to IDLE the same clk; busy=0; the partial word is discarded (no mem_wen).
  - bitcnt==0 and command received: frame_done=1.
  - bitcnt!=0, or CMD not completed: err_abort=1.
- Simultaneous events:
  - cs_rise beats a pending sclk edge in the same clk.
  - A mem_wen due on the same clk as cs_rise is still issued; the word completed earlier.
- Back-to-back frames: cs_fall in the clk after IDLE entry is accepted.
- sclk edges while cs_n is high: ignored.

Test Plan:
- Write burst: CS low, send 0x05, 0xA1, 0xB2, CS high -> mem_wen at addr 0x05=0xA1, 0x06=0xB2; frame_done pulse 1; err_abort 0.
- Read burst: mem preloaded 0x10=0x3C, 0x11=0xC3; send 0x90 then 16 dummy clocks -> MISO bytes 0x3C, 0xC3 MSB first; mem_ren at 0x10, 0x11, 0x12.
- Wrap: write command 0x7F, two data bytes 0x11, 0x22 -> writes 0x7F=0x11, 0x00=0x22.
- Abort: write command 0x02, then 5 bits, CS high -> no mem_wen for the partial word; err_abort=1; busy=0 next clk; next frame decodes normally.
- Reset mid-frame: assert rst after 3 bits of a command and release with CS still low; 10 more clocks -> no mem_wen/mem_ren. After CS high/low, a command 0x01 + 0x55 writes addr 1=0x55.
- Oversampling edge: SCLK = clk/8, read at addr 0x00 holding 0x80 -> MISO=1 stable before the first data sclk rise, then 0 for the following 7 bits.
